// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath widths and the MEM->WB payload layout.
package pipe_pkg;

    localparam int PIPE_XLEN       = 32;
    localparam int PIPE_REG_ADDR_W = 5;

    // Field order is the packing order used by every stage that moves this payload.
    typedef struct packed {
        logic [PIPE_XLEN-1:0]       alu;
        logic [PIPE_XLEN-1:0]       pc;
        logic [PIPE_XLEN-1:0]       ldata;
        logic                       is_load;
        logic [PIPE_REG_ADDR_W-1:0] rd;
        logic                       we;
    } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register. MEM_WB_SKID_EN adds a skid entry (S) behind the
// main entry (M) so In_Ready is registered; otherwise a single entry with combinational In_Ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Flush,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [W-1:0] In_Data,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [W-1:0] Out_Data
);

    logic         m_valid;
    logic [W-1:0] m_data;
    logic         accept;
    logic         xfer_out;

    assign xfer_out  = m_valid & Out_Ready;
    // Flush wins over a same-cycle accept, so the incoming payload is simply dropped.
    assign accept    = In_Valid & In_Ready & ~Flush;
    assign Out_Valid = m_valid;
    assign Out_Data  = m_data;

`ifdef MEM_WB_SKID_EN
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         m_free;

    // S can only be occupied while M is held, so In_Ready never depends on Out_Ready.
    assign In_Ready = ~s_valid;
    assign m_free   = ~m_valid | xfer_out;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (Flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            // When S is full no accept is possible, so at most one of these sources is live.
            m_valid <= s_valid | accept;
            s_valid <= 1'b0;
        end else if (accept) begin
            s_valid <= 1'b1;
        end
    end

    // NOTE: payload registers are reset because WB outputs must read zero after Reset;
    // Flush only drops the valid bits and leaves the payload untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_data <= '0;
            s_data <= '0;
        end else begin
            if (m_free && s_valid) begin
                m_data <= s_data;
            end else if (m_free && accept) begin
                m_data <= In_Data;
            end
            if (!m_free && accept) begin
                s_data <= In_Data;
            end
        end
    end
`else
    assign In_Ready = ~m_valid | Out_Ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_valid <= 1'b0;
        end else if (Flush) begin
            m_valid <= 1'b0;
        end else if (In_Ready) begin
            m_valid <= In_Valid;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_data <= '0;
        end else if (accept) begin
            m_data <= In_Data;
        end
    end
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage with handshake, flush, x0-qualified write enable and write-back mux.
// Build option: define MEM_WB_SKID_EN for the two-entry skid variant with registered In_Ready.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN       = PIPE_XLEN,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [XLEN-1:0]       Alu_Out_MEM,
    input  logic [XLEN-1:0]       PC_MEM,
    input  logic [XLEN-1:0]       Loaded_Data_MEM,
    input  logic                  I_Type_Load_MEM,
    input  logic [REG_ADDR_W-1:0] rd_MEM,
    input  logic                  Write_Enable_MEM,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [XLEN-1:0]       Alu_Out_WB,
    output logic [XLEN-1:0]       PC_WB,
    output logic [XLEN-1:0]       Loaded_Data_WB,
    output logic                  Write_Back_Control_WB,
    output logic [REG_ADDR_W-1:0] rd_WB,
    output logic                  Write_Enable_WB,
    output logic [XLEN-1:0]       Wb_Data_WB
);

    // Same field order as pipe_pkg::mem_wb_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       ldata;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } payload_t;

    payload_t in_payload;
    payload_t out_payload;

    assign in_payload = '{
        alu:     Alu_Out_MEM,
        pc:      PC_MEM,
        ldata:   Loaded_Data_MEM,
        is_load: I_Type_Load_MEM,
        rd:      rd_MEM,
        we:      Write_Enable_MEM
    };

    pipe_skid_buf #(
        .W($bits(payload_t))
    ) u_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Data   (in_payload),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (out_payload)
    );

    assign Alu_Out_WB            = out_payload.alu;
    assign PC_WB                 = out_payload.pc;
    assign Loaded_Data_WB        = out_payload.ldata;
    assign Write_Back_Control_WB = out_payload.is_load;
    assign rd_WB                 = out_payload.rd;

    // x0 is hard-wired zero, so a write to it is never presented to the register file.
    assign Write_Enable_WB = Out_Valid & out_payload.we & (out_payload.rd != '0);
    assign Wb_Data_WB      = out_payload.is_load ? out_payload.ldata : out_payload.alu;

endmodule
